// File: rtl/ps2_keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: bus register map, status bit
// positions and the frame FSM state encoding.
package ps2_keyboard_pkg;

    localparam int unsigned BUS_W  = 16;
    localparam int unsigned DATA_W = 8;

    // addr[1] selects the register
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int unsigned STAT_NEMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT   = 1;
    localparam int unsigned STAT_FERR_BIT   = 2;
    localparam int unsigned STAT_OVF_BIT    = 3;

    localparam int unsigned CLR_FERR_BIT = 2;
    localparam int unsigned CLR_OVF_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    function automatic logic [BUS_W-1:0] status_word(input logic ferr, input logic ovf,
                                                      input logic full, input logic nempty);
        logic [BUS_W-1:0] w;
        w                  = '0;
        w[STAT_NEMPTY_BIT] = nempty;
        w[STAT_FULL_BIT]   = full;
        w[STAT_FERR_BIT]   = ferr;
        w[STAT_OVF_BIT]    = ovf;
        return w;
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Scancode FIFO; a pop in the same cycle as a push frees the slot the push needs,
// so push+pop while full is accepted.
module ps2_kbd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i & ~empty_q;
        do_push  = push_i & (~full_q | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset; empty gates every consumer of head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scancode FIFO and a two-register bus interface.
// Optional mid-frame watchdog enabled by macro PS2_KEYBOARD_TIMEOUT_EN.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [1:0]  bwe,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        ps2_clk,
    input  logic        ps2_data
);

    logic [1:0]        clk_sync_q, data_sync_q;
    logic              clk_prev_q;
    logic              fall_c, bit_c, timeout_c;
    frame_state_e      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_ok_q, par_ok_d;
    logic              push_c, ferr_set_c;
    logic              ferr_q, ferr_d, ovf_q, ovf_d;
    logic              wr_c, pop_c, clr_c, drop_c;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [BUS_W-1:0]  dout_q, dout_d;

    // Synchronizers idle high like the PS/2 lines themselves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall_c = clk_prev_q & ~clk_sync_q[1];
    assign bit_c  = data_sync_q[1];

`ifdef PS2_KEYBOARD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d  = to_cnt_q + TW'(1);
        if (fall_c || state_q == ST_IDLE) to_cnt_d = '0;
        timeout_c = (state_q != ST_IDLE) && !fall_c && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_to_c;
    assign unused_to_c = (TIMEOUT_CYCLES == 0);
    assign timeout_c   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = ST_IDLE;
        end else if (fall_c) begin
            case (state_q)
                ST_IDLE:   if (!bit_c) state_d = ST_SHIFT;
                ST_SHIFT:  if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        push_c     = 1'b0;
        ferr_set_c = timeout_c;
        if (fall_c && !timeout_c) begin
            case (state_q)
                ST_IDLE:   bit_cnt_d = '0;
                ST_SHIFT: begin
                    shift_d   = {bit_c, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: par_ok_d = ^{shift_q, bit_c};
                ST_STOP: begin
                    if (bit_c && par_ok_q) push_c     = 1'b1;
                    else                   ferr_set_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    ps2_kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .wdata_i (shift_q),
        .pop_i   (pop_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Only addr[1] and din[3:2] matter to this block.
    logic unused_bus_c;
    assign unused_bus_c = ^{addr[15:2], addr[0], din[15:4], din[1:0]};

    always_comb begin
        wr_c   = |bwe;
        pop_c  = wr_c && (addr[1] == REG_DATA);
        clr_c  = wr_c && (addr[1] == REG_STAT);
        drop_c = push_c & fifo_full & ~pop_c;
        ferr_d = (ferr_q & ~(clr_c & din[CLR_FERR_BIT])) | ferr_set_c;
        ovf_d  = (ovf_q & ~(clr_c & din[CLR_OVF_BIT])) | drop_c;
        dout_d = '0;
        if (addr[1] == REG_STAT) dout_d = status_word(ferr_q, ovf_q, fifo_full, ~fifo_empty);
        else if (!fifo_empty)    dout_d = {7'b0, 1'b1, fifo_head};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            ferr_q <= ferr_d;
            ovf_q  <= ovf_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: queue-based model of FIFO and sticky flags,
// one compare process checking dout on every requested read.
module tb_ps2_keyboard;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned TO        = 200;
    localparam int unsigned WDOG_CYC  = 400000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] addr = '0;
    logic [1:0]  bwe = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .bwe(bwe), .din(din),
        .dout(dout), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    logic [7:0]  mq[$];
    bit          m_ferr = 0, m_ovf = 0;
    int          n_vec = 0, n_err = 0;
    logic        chk_en = 1'b0;
    logic [15:0] chk_exp = '0;
    string       chk_name = "";
    bit          done = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (dout !== chk_exp) begin
                n_err++;
                $display("FAIL %s: dout=%04h expected=%04h", chk_name, dout, chk_exp);
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!done && cyc < WDOG_CYC) begin
            @(posedge clk);
            cyc++;
        end
        if (!done) begin
            n_err++;
            $display("FAIL watchdog: sequence did not finish within %0d cycles", WDOG_CYC);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    function automatic logic [15:0] m_data();
        if (mq.size() == 0) return 16'h0000;
        return {8'h01, mq[0]};
    endfunction

    function automatic logic [15:0] m_stat();
        return {12'h000, m_ovf, m_ferr, mq.size() == DEPTH, mq.size() != 0};
    endfunction

    task automatic expect_next(input logic [15:0] e, input string n);
        chk_exp  = e;
        chk_name = n;
        chk_en   = 1'b1;
        @(negedge clk);
        #1 chk_en = 1'b0;
    endtask

    task automatic rd(input logic a, input logic [15:0] e, input string n);
        @(negedge clk);
        addr = {14'b0, a, 1'b0};
        bwe  = 2'b00;
        @(posedge clk);
        #1 expect_next(e, n);
    endtask

    task automatic rd_model(input logic a, input string n);
        rd(a, a ? m_stat() : m_data(), n);
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        @(negedge clk);
        addr = {14'b0, a, 1'b0};
        din  = d;
        bwe  = 2'b11;
        @(negedge clk);
        bwe  = 2'b00;
        if (!a) begin
            if (mq.size() != 0) void'(mq.pop_front());
        end else begin
            if (d[2]) m_ferr = 0;
            if (d[3]) m_ovf = 0;
        end
    endtask

    // One PS/2 bit; optionally pops the FIFO in the cycle the stop edge is processed.
    task automatic ps2_bit(input logic b, input bit pop_at_fall);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_at_fall) begin
            @(negedge clk);
            @(negedge clk);
            addr = 16'h0000;
            bwe  = 2'b11;
            @(negedge clk);
            bwe  = 2'b00;
            repeat (17) @(negedge clk);
        end else begin
            repeat (20) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
        ps2_bit((~^b) ^ bad_par, 0);
        ps2_bit(~bad_stop, pop_at_stop);
        if (pop_at_stop && mq.size() != 0) void'(mq.pop_front());
        if (!bad_par && !bad_stop) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovf = 1;
        end else begin
            m_ferr = 1;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits, input logic [7:0] b);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        n_vec++;
        if (dout !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: dout=%04h expected=0000 while reset_n low", dout);
        end
        expect_next(16'h0000, "reset_dout");
        reset_n = 1'b1;
        rd(0, 16'h0000, "rst_data");
        rd(1, 16'h0000, "rst_stat");

        // Good frame
        send_frame(8'h1C, 0, 0, 0);
        rd(0, 16'h011C, "good_data_lit");
        rd(1, 16'h0001, "good_stat_lit");
        rd_model(0, "good_data");

        // Read and pop in the same cycle returns the pre-pop head
        @(negedge clk);
        addr = 16'h0000; din = 16'h0000; bwe = 2'b11;
        @(posedge clk);
        #1 bwe = 2'b00;
        expect_next(16'h011C, "rd_before_pop");
        void'(mq.pop_front());
        rd_model(1, "after_pop_stat");
        wr(0, 16'h0000);
        rd(0, 16'h0000, "pop_empty_data");
        rd_model(1, "pop_empty_stat");

        // Parity and stop errors, selective clearing
        send_frame(8'h1C, 1, 0, 0);
        rd(1, 16'h0004, "parerr_stat_lit");
        rd_model(0, "parerr_data");
        wr(1, 16'h0004);
        rd(1, 16'h0000, "ferr_clr_lit");
        send_frame(8'h55, 0, 1, 0);
        rd_model(1, "stoperr_stat");
        wr(1, 16'h0008);
        rd_model(1, "ferr_kept");
        wr(1, 16'h0004);
        rd_model(1, "ferr_clr2");

        // Overflow: DEPTH+1 bytes without popping
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
        rd(1, 16'h000B, "ovf_stat_lit");
        rd_model(1, "ovf_stat");
        for (int i = 1; i <= 8; i++) begin
            rd(0, 16'h0100 | 16'(i), "pop_order_lit");
            rd_model(0, "pop_order");
            wr(0, 16'h0000);
        end
        rd_model(0, "drained_data");
        rd(1, 16'h0008, "drained_stat_lit");
        wr(1, 16'h0008);
        rd_model(1, "ovf_clr");

        // Full FIFO: pop coincides with the stop edge
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
        rd(1, 16'h0003, "full_stat_lit");
        send_frame(8'hA5, 0, 0, 1);
        rd(1, 16'h0003, "pushpop_stat_lit");
        rd_model(1, "pushpop_stat");
        for (int i = 0; i < 7; i++) begin
            rd_model(0, "pushpop_order");
            wr(0, 16'h0000);
        end
        rd(0, 16'h01A5, "pushpop_last_lit");
        wr(0, 16'h0000);
        rd_model(1, "pushpop_drained");

        // Reset mid-frame with data and a pending error
        send_frame(8'h33, 0, 0, 0);
        send_frame(8'h44, 1, 0, 0);
        rd_model(1, "pre_rst_stat");
        send_partial(5, 8'hE7);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_ferr = 0;
        m_ovf  = 0;
        rd(1, 16'h0000, "rst_mid_stat_lit");
        rd(0, 16'h0000, "rst_mid_data_lit");
        send_frame(8'hF0, 0, 0, 0);
        rd(0, 16'h01F0, "post_rst_data_lit");
        rd(1, 16'h0001, "post_rst_stat_lit");
        wr(0, 16'h0000);
        rd_model(1, "post_rst_drained");

`ifdef PS2_KEYBOARD_TIMEOUT_EN
        // Stalled frame aborts after the watchdog interval
        send_partial(3, 8'h5A);
        repeat (TO + 2) @(negedge clk);
        m_ferr = 1;
        rd(1, 16'h0004, "timeout_stat_lit");
        send_frame(8'h5A, 0, 0, 0);
        rd(0, 16'h015A, "timeout_next_data_lit");
        rd(1, 16'h0005, "timeout_next_stat_lit");
        rd_model(0, "timeout_next_data");
`endif

        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
